// File: rtl/ram_bitaddr_mp_wiped_if.sv
// Per-port access bundle for the multi-port bit-addressable scratch RAM.
// Port p occupies slice p of each packed vector.
interface ram_bitaddr_mp_wiped_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WIN_W  = 17
);
  logic [NPORTS*ADDR_W-1:0] addr;
  logic [NPORTS*WIN_W-1:0]  din;
  logic [NPORTS-1:0]        store;
  logic [NPORTS-1:0]        wide;
  logic                     wipe;
  logic [NPORTS-1:0]        dout;
  logic [NPORTS*WIN_W-1:0]  dout_win;
  logic                     busy;
  logic                     collision;

  modport master (
    output addr, din, store, wide, wipe,
    input  dout, dout_win, busy, collision
  );

  modport slave (
    input  addr, din, store, wide, wipe,
    output dout, dout_win, busy, collision
  );
endinterface

// File: rtl/ram_bitaddr_mp_wiped.sv
// Multi-port bit-addressable RAM with wrapping window access, highest-port-wins
// write merging with collision flag, and a chunked multi-cycle wipe engine.
module ram_bitaddr_mp_wiped #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WIN_W  = 17,
  parameter int unsigned WIPE_W = 64
) (
  input logic                    clk,
  input logic                    clear,
  ram_bitaddr_mp_wiped_if.slave  bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NCHUNK = DEPTH / WIPE_W;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {StIdle, StWiping} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     chunk_q, chunk_d;
  logic              busy;
  logic              quiet;

  logic [DEPTH-1:0]  mem_q, mem_d;
  logic [DEPTH-1:0]  wmask [NPORTS];
  logic [DEPTH-1:0]  wdata [NPORTS];
  logic              coll_d;

  logic [NPORTS-1:0]       rd_bit;
  logic [NPORTS*WIN_W-1:0] rd_win;
  logic [NPORTS-1:0]       dout_q;
  logic [NPORTS*WIN_W-1:0] dout_win_q;
  logic                    collision_q;

  // Wipe engine
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= StWiping;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    unique case (state_q)
      StIdle: begin
        if (bus.wipe) begin
          state_d = StWiping;
          chunk_d = '0;
        end
      end
      StWiping: begin
        if (bus.wipe) begin
          chunk_d = '0;
        end else if (chunk_q == CW'(NCHUNK - 1)) begin
          state_d = StIdle;
          chunk_d = '0;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
    endcase
  end

  assign busy = (state_q == StWiping);
  // Outputs read as zero on any edge that starts, continues or finishes a wipe.
  assign quiet = busy || (state_d == StWiping);

  // Per-port write footprint, expanded to full array width
  always_comb begin
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] idx;
    base = '0;
    idx  = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      wmask[p] = '0;
      wdata[p] = '0;
      if (bus.store[p] && !busy) begin
        base = bus.addr[p*ADDR_W +: ADDR_W];
        if (bus.wide[p]) begin
          for (int unsigned k = 0; k < WIN_W; k++) begin
            idx = base + ADDR_W'(k);
            wmask[p][idx] = 1'b1;
            wdata[p][idx] = bus.din[p*WIN_W + WIN_W - 1 - k];
          end
        end else begin
          wmask[p][base] = 1'b1;
          wdata[p][base] = bus.din[p*WIN_W];
        end
      end
    end
  end

  // Merge in ascending port order so the highest writer wins each bit.
  always_comb begin
    logic [DEPTH-1:0] seen;
    logic [DEPTH-1:0] hit;
    seen  = '0;
    hit   = '0;
    mem_d = mem_q;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      hit   = hit | (seen & wmask[p]);
      seen  = seen | wmask[p];
      mem_d = (mem_d & ~wmask[p]) | (wdata[p] & wmask[p]);
    end
    coll_d = |hit;
    if (busy) begin
      mem_d[int'(chunk_q) * WIPE_W +: WIPE_W] = '0;
    end
  end

  // Array has no reset; clear only freezes it until the wipe takes over.
  always_ff @(posedge clk) begin
    if (!clear) begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] base;
    base   = '0;
    rd_bit = '0;
    rd_win = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      base      = bus.addr[p*ADDR_W +: ADDR_W];
      rd_bit[p] = mem_q[base];
      for (int unsigned k = 0; k < WIN_W; k++) begin
        rd_win[p*WIN_W + WIN_W - 1 - k] = mem_q[base + ADDR_W'(k)];
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      dout_q      <= '0;
      dout_win_q  <= '0;
      collision_q <= 1'b0;
    end else if (quiet) begin
      dout_q      <= '0;
      dout_win_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      dout_q      <= rd_bit;
      dout_win_q  <= rd_win;
      collision_q <= coll_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_win  = dout_win_q;
  assign bus.busy      = busy;
  assign bus.collision = collision_q;

endmodule

// File: doc/ram_bitaddr_mp_wiped.md
# ram_bitaddr_mp_wiped

Parametrised multi-port, bit-addressable scratch RAM for the parallel multi-core build. Each of NPORTS cores gets one independent port that does single-bit or WIN_W-bit window writes and registered single-bit plus window reads. Window addressing wraps around. Multi-port write collisions are resolved deterministically and flagged. Clearing the array is done by a bounded, multi-cycle wipe engine with a busy flag, not a single-cycle full-array reset.

## Interface
Parameters:
- NPORTS, 4, number of independent access ports (1..8)
- ADDR_W, 14, bit-address width; DEPTH = 2**ADDR_W bits
- WIN_W, 17, window width for window reads and wide writes (1..32, <= DEPTH)
- WIPE_W, 64, bits zeroed per wipe cycle (power of two, divides DEPTH)

Ports:
- clk  in  1  single clock, all state changes on rising edge
- clear  in  1  reset, asynchronous, active-high; also starts a wipe
- addr  in  NPORTS*ADDR_W  per-port bit address, port p in slice p
- din  in  NPORTS*WIN_W  per-port write data, port p in slice p
- store  in  NPORTS  per-port write enable
- wide  in  NPORTS  1 = WIN_W-bit window write, 0 = single-bit write
- wipe  in  1  synchronous request to zero the whole array
- dout  out  NPORTS  registered bit memory[addr_p]
- dout_win  out  NPORTS*WIN_W  registered window for port p
- busy  out  1  wipe in progress
- collision  out  1  registered pulse: two or more ports wrote the same bit last cycle

## Operation
- Window bit order: dout_win_p[WIN_W-1-k] = memory[(addr_p + k) mod DEPTH], for k = 0..WIN_W-1. The MSB is memory[addr_p]. Wrap is modulo DEPTH.
- Wide write: memory[(addr_p + k) mod DEPTH] <= din_p[WIN_W-1-k], for all k.
- Narrow write: memory[addr_p] <= din_p[0]. All other din bits are ignored.
- Collision rule: per bit, the highest-index writing port wins. collision is 1 the cycle after any bit was targeted by two or more ports, including overlap between wide windows, narrow writes, or a mix of the two.
- Read-during-write: reads sample pre-edge contents. The same port or another port reading a bit being written that cycle gets the old value; the new value is visible on the next read.
- Wipe FSM, two states:
  - IDLE → WIPING on clear (async), or on wipe=1 at a rising edge.
  - WIPING: chunk counter c starts at 0. Each edge zeroes bits [c*WIPE_W, c*WIPE_W+WIPE_W-1] and increments c.
  - WIPING → IDLE on the edge that zeroes the last chunk (c = DEPTH/WIPE_W - 1).
  - wipe=1 while WIPING restarts with c = 0.
- While busy=1:
  - All store inputs are ignored.
  - dout and dout_win register 0.
  - collision registers 0.
- Array contents are undefined from power-up until the first wipe completes.

## Timing
- clear asserted: asynchronously busy=1, c=0, dout=0, dout_win=0, collision=0. These hold while clear=1, and no memory bits change.
- After clear deasserts, the wipe takes exactly DEPTH/WIPE_W rising edges. busy goes 0 after the last of them.
- clear reasserted mid-wipe: asynchronous restart from c=0.
- wipe sampled at edge N: busy=1 after edge N, and chunk 0 is zeroed at edge N+1. busy=0 after edge N + DEPTH/WIPE_W.
- Read latency is 1 cycle. addr_p applied before edge N appears on dout/dout_win after edge N. There is no read enable; outputs update every edge.
- Write latency is 1 edge. A write at edge N is readable by an address presented before edge N+1, with data out after edge N+1.
- collision is valid for exactly one cycle, after the edge that performed the conflicting writes.

## Test plan
Use NPORTS=4, ADDR_W=8, WIN_W=17, WIPE_W=16, giving DEPTH=256 and a 16-cycle wipe.
- Reset/wipe: pulse clear, then deassert. Require busy=1 for exactly 16 edges, then 0. All 256 bits read as 0 via windows. Store during busy at addr 5 with din=1 is ignored.
- Wide write with wrap: port 0 does a wide write at addr 250 with din=17'h1_2345. Port 1 reads addr 250, and next cycle dout_win=17'h1_2345. memory[0..10] holds din bits [10:0] (the low bits) in order; memory[0] = din[10].
- Collision: port 1 and port 3 both do a narrow write to addr 40, with din0=1 and din0=0 respectively. Next cycle collision=1 and the read of addr 40 gives 0. A non-overlapping write gives collision=0.
- Read-during-write: port 2 reads addr 7 while port 0 narrow-writes 1 there, with the bit previously 0. dout_2=0 after that edge and 1 after the next.
- Mid-wipe restart: with the array previously written with ones, assert wipe at wipe cycle 9. Require busy to stay 1 for 16 more edges, then the array is all zero.
- Async clear mid-traffic: assert clear between edges. Outputs go 0 immediately, without a clock edge, and busy=1.
